// File: rtl/flag_sequencer_pkg.sv
// Shared types and display constants for the flag display pipeline
// (sync generator, flag sequencer, colour lookup).
package flag_sequencer_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;

  typedef logic [2:0] flag_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WIPE = 2'd2
  } state_t;

  // Next flag in the cycle, wrapping from num_flags-1 back to 0.
  function automatic flag_id_t advance_flag(input flag_id_t cur,
                                            input int unsigned num_flags);
    if ((int'(cur) + 1) >= int'(num_flags)) return '0;
    return cur + 3'd1;
  endfunction

endpackage

// File: rtl/flag_sequencer_if.sv
// Sync-generator inputs and pixel/status outputs of the flag sequencer.
interface flag_sequencer_if;
  import flag_sequencer_pkg::*;

  logic       enable;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;

  flag_id_t   flag_sel;
  flag_id_t   pix_flag;
  logic [2:0] stripe_idx;
  logic       pix_valid;
  logic       frame_tick;
  logic       busy;

  modport master (
    output enable, hpos, vpos, display_on,
    input  flag_sel, pix_flag, stripe_idx, pix_valid, frame_tick, busy
  );

  modport slave (
    input  enable, hpos, vpos, display_on,
    output flag_sel, pix_flag, stripe_idx, pix_valid, frame_tick, busy
  );
endinterface

// File: rtl/flag_sequencer_stripe_tracker.sv
// Tracks which horizontal stripe the current line falls in.
module stripe_tracker #(
  parameter int unsigned STRIPE_H = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [2:0] stripe
);

  localparam logic [8:0] ROW_LAST = 9'(STRIPE_H - 1);

  logic [8:0] row_cnt_q, row_cnt_d;
  logic [2:0] stripe_q, stripe_d;

  // Line-start update: restart at the top of frame, else count rows per stripe.
  always_comb begin
    row_cnt_d = row_cnt_q;
    stripe_d  = stripe_q;
    if (hpos == '0) begin
      if (vpos == '0) begin
        row_cnt_d = '0;
        stripe_d  = '0;
      end else if (row_cnt_q == ROW_LAST) begin
        row_cnt_d = '0;
        stripe_d  = (stripe_q == 3'd7) ? stripe_q : stripe_q + 3'd1;
      end else begin
        row_cnt_d = row_cnt_q + 9'd1;
      end
    end
  end

  // Row and stripe counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q <= '0;
      stripe_q  <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      stripe_q  <= stripe_d;
    end
  end

  // The line-start update applies to the pixel at hpos==0 itself.
  assign stripe = stripe_d;

endmodule

// File: rtl/flag_sequencer.sv
// Cycles through flag patterns: holds each for a number of frames, then
// wipes left-to-right to the next one. Emits per-pixel flag/stripe data.
module flag_sequencer
  import flag_sequencer_pkg::*;
#(
  parameter int unsigned NUM_FLAGS   = 6,
  parameter int unsigned HOLD_FRAMES = 180,
  parameter int unsigned WIPE_STEP   = 8,
  parameter int unsigned STRIPE_H    = 80,
  parameter int unsigned H_DISPLAY   = flag_sequencer_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY   = flag_sequencer_pkg::V_DISPLAY
) (
  input  logic             clk,
  input  logic             rst_n,
  flag_sequencer_if.slave  bus
);

  localparam logic [9:0]  HOLD_LAST = 10'(HOLD_FRAMES - 1);
  localparam logic [10:0] STEP      = 11'(WIPE_STEP);
  localparam logic [10:0] H_LIMIT   = 11'(H_DISPLAY);
  localparam logic [9:0]  V_TICK    = 10'(V_DISPLAY);

  state_t     state_q, state_d;
  logic [9:0] hold_cnt_q, hold_cnt_d;
  logic [10:0] wipe_pos_q, wipe_pos_d;
  logic [10:0] wipe_sum;
  flag_id_t   flag_sel_q, flag_sel_d;
  flag_id_t   next_sel_q, next_sel_d;
  logic       frame_tick_q, frame_tick_d;
  flag_id_t   pix_flag_q, pix_flag_d;
  logic [2:0] stripe_idx_q, stripe_idx_d;
  logic       pix_valid_q, pix_valid_d;
  logic [2:0] stripe;
  logic       show_wipe;

  stripe_tracker #(.STRIPE_H(STRIPE_H)) u_stripe (
    .clk    (clk),
    .rst_n  (rst_n),
    .hpos   (bus.hpos),
    .vpos   (bus.vpos),
    .stripe (stripe)
  );

  assign frame_tick_d = (bus.hpos == '0) && (bus.vpos == V_TICK);
  assign wipe_sum     = wipe_pos_q + STEP;

  // Sequencing FSM; all transitions happen only on the registered frame tick.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wipe_pos_d = wipe_pos_q;
    flag_sel_d = flag_sel_q;
    next_sel_d = next_sel_q;
    if (frame_tick_q) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enable) begin
            // A frozen wipe (non-zero edge) resumes instead of restarting hold.
            if (wipe_pos_q != '0) begin
              state_d = ST_WIPE;
            end else begin
              state_d    = ST_HOLD;
              hold_cnt_d = '0;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.enable) begin
            state_d = ST_IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            next_sel_d = advance_flag(flag_sel_q, NUM_FLAGS);
            wipe_pos_d = '0;
            state_d    = ST_WIPE;
          end else begin
            hold_cnt_d = hold_cnt_q + 10'd1;
          end
        end
        ST_WIPE: begin
          if (!bus.enable) begin
            state_d = ST_IDLE;
          end else if (wipe_sum >= H_LIMIT) begin
            flag_sel_d = next_sel_q;
            wipe_pos_d = '0;
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end else begin
            wipe_pos_d = wipe_sum;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      wipe_pos_q   <= '0;
      flag_sel_q   <= '0;
      next_sel_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      wipe_pos_q   <= wipe_pos_d;
      flag_sel_q   <= flag_sel_d;
      next_sel_q   <= next_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Per-pixel flag choice: left of the wipe edge shows the incoming flag.
  always_comb begin
    show_wipe    = (state_q == ST_WIPE) ||
                   ((state_q == ST_IDLE) && (wipe_pos_q != '0));
    pix_flag_d   = flag_sel_q;
    stripe_idx_d = stripe;
    pix_valid_d  = bus.display_on;
    if (!bus.display_on) begin
      pix_flag_d = '0;
    end else if (show_wipe && ({1'b0, bus.hpos} < wipe_pos_q)) begin
      pix_flag_d = next_sel_q;
    end
  end

  // One-cycle pixel pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_flag_q   <= '0;
      stripe_idx_q <= '0;
      pix_valid_q  <= 1'b0;
    end else begin
      pix_flag_q   <= pix_flag_d;
      stripe_idx_q <= stripe_idx_d;
      pix_valid_q  <= pix_valid_d;
    end
  end

  assign bus.flag_sel   = flag_sel_q;
  assign bus.pix_flag   = pix_flag_q;
  assign bus.stripe_idx = stripe_idx_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.busy       = (state_q == ST_WIPE);

endmodule
